// File: rtl/referee_pkg.sv
// rtl/referee_pkg.sv - shared state encoding and default constants for the round referee
package referee_pkg;

  typedef enum logic [2:0] {
    PLAY   = 3'd0,
    SHOW_L = 3'd1,
    SHOW_R = 3'd2,
    NEXT   = 3'd3,
    OVER   = 3'd4
  } ref_state_t;

  localparam int MAX_SCORE_DEF   = 7;
  localparam int HOLD_CYCLES_DEF = 4;

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - counts enabled cycles from clear and flags the last hold cycle
module hold_timer #(
  parameter int HOLD_W      = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [HOLD_W-1:0] hold;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hold <= '0;
    end else if (clear) begin
      hold <= '0;
    end else if (enable) begin
      hold <= hold + HOLD_W'(1);
    end
  end

  // done marks the cycle whose edge ends the hold window
  assign done = enable && (hold == HOLD_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/round_referee.sv
// rtl/round_referee.sv - tug-of-war round referee: win detect, scoring, hold, re-centre, game over
module round_referee
  import referee_pkg::*;
#(
  parameter int SCORE_W     = 3,
  parameter int MAX_SCORE   = MAX_SCORE_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int HOLD_W      = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               L,
  input  logic               R,
  input  logic               leftEnd,
  input  logic               rightEnd,
  output logic               next,
  output logic               winL,
  output logic               winR,
  output logic [SCORE_W-1:0] scoreL,
  output logic [SCORE_W-1:0] scoreR,
  output logic               gameOver
);

  ref_state_t state;
  logic       in_show;
  logic       hold_done;
  logic       left_win;
  logic       right_win;

  assign in_show   = (state == SHOW_L) || (state == SHOW_R);
  // A simultaneous press cancels out, so both ends lit never yields two winners
  assign left_win  = L && !R && leftEnd;
  assign right_win = R && !L && rightEnd;

  hold_timer #(
    .HOLD_W      (HOLD_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (!in_show),
    .enable (in_show),
    .done   (hold_done)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= PLAY;
      scoreL   <= '0;
      scoreR   <= '0;
      next     <= 1'b0;
      winL     <= 1'b0;
      winR     <= 1'b0;
      gameOver <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (left_win) begin
            state  <= SHOW_L;
            scoreL <= scoreL + SCORE_W'(1);
            winL   <= 1'b1;
          end else if (right_win) begin
            state  <= SHOW_R;
            scoreR <= scoreR + SCORE_W'(1);
            winR   <= 1'b1;
          end
        end
        SHOW_L: begin
          if (hold_done) begin
            if (scoreL == SCORE_W'(MAX_SCORE)) begin
              state    <= OVER;
              gameOver <= 1'b1;
            end else begin
              state <= NEXT;
              winL  <= 1'b0;
              next  <= 1'b1;
            end
          end
        end
        SHOW_R: begin
          if (hold_done) begin
            if (scoreR == SCORE_W'(MAX_SCORE)) begin
              state    <= OVER;
              gameOver <= 1'b1;
            end else begin
              state <= NEXT;
              winR  <= 1'b0;
              next  <= 1'b1;
            end
          end
        end
        NEXT: begin
          state <= PLAY;
          next  <= 1'b0;
        end
        OVER: begin
          state <= OVER;
        end
        default: begin
          state <= PLAY;
          next  <= 1'b0;
          winL  <= 1'b0;
          winR  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_referee.sv
// tb/tb_round_referee.sv - directed and randomized checks of round_referee against a round-timeline model
module tb_round_referee;

  localparam int HOLD = 4;
  localparam int MAXS = 7;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       L = 1'b0, R = 1'b0, leftEnd = 1'b0, rightEnd = 1'b0;
  logic       next, winL, winR, gameOver;
  logic [2:0] scoreL, scoreR;

  int total = 0;
  int passed = 0;

  // Model: scores plus which side won the current round and edges elapsed since that win
  int sl, sr, side, t;

  round_referee dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .L        (L),
    .R        (R),
    .leftEnd  (leftEnd),
    .rightEnd (rightEnd),
    .next     (next),
    .winL     (winL),
    .winR     (winR),
    .scoreL   (scoreL),
    .scoreR   (scoreR),
    .gameOver (gameOver)
  );

  always #5 Clock = ~Clock;

  function automatic bit side_maxed();
    return (side == 1 && sl == MAXS) || (side == 2 && sr == MAXS);
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic check_all(input string tag);
    bit over;
    over = side_maxed() && t >= HOLD;
    check({tag, ".next"},     int'(next),     (side != 0 && t == HOLD && !side_maxed()) ? 1 : 0);
    check({tag, ".winL"},     int'(winL),     (side == 1 && (t < HOLD || over)) ? 1 : 0);
    check({tag, ".winR"},     int'(winR),     (side == 2 && (t < HOLD || over)) ? 1 : 0);
    check({tag, ".scoreL"},   int'(scoreL),   sl);
    check({tag, ".scoreR"},   int'(scoreR),   sr);
    check({tag, ".gameOver"}, int'(gameOver), over ? 1 : 0);
  endtask

  task automatic model_reset();
    sl = 0; sr = 0; side = 0; t = 0;
  endtask

  task automatic model_edge(input bit l, input bit r, input bit le, input bit re);
    if (side == 0) begin
      if (l && !r && le) begin side = 1; t = 0; sl++; end
      else if (r && !l && re) begin side = 2; t = 0; sr++; end
    end else begin
      if (t < 1000) t++;
      if (t == HOLD + 1 && !side_maxed()) side = 0;
    end
  endtask

  // Apply inputs for one clock edge, then compare just after the edge
  task automatic step(input string tag, input bit l, input bit r, input bit le, input bit re);
    L = l; R = r; leftEnd = le; rightEnd = re;
    @(posedge Clock);
    #1;
    model_edge(l, r, le, re);
    check_all(tag);
    L = 1'b0; R = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, leftEnd, rightEnd);
  endtask

  task automatic hit_reset(input string tag);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge Clock);
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge Clock);
    #2;
    Reset = 1'b0;

    // 1: idle after reset
    idle("idle", 10);

    // 2: left win, hold, next pulse, back to play
    step("lwin", 1'b1, 1'b0, 1'b1, 1'b0);
    idle("lhold", HOLD + 2);

    // 3: simultaneous keys cancel
    step("both_keys", 1'b1, 1'b1, 1'b1, 1'b1);
    idle("both_idle", 3);

    // 4: key without end light ignored; keys during show ignored
    step("l_no_end", 1'b1, 1'b0, 1'b0, 1'b0);
    step("lwin2", 1'b1, 1'b0, 1'b1, 1'b1);
    step("r_in_show", 1'b0, 1'b1, 1'b1, 1'b1);
    step("l_in_show", 1'b1, 1'b0, 1'b1, 1'b1);
    idle("lhold2", HOLD + 1);

    // 5: seven right wins end the game; keys afterwards ignored
    for (int k = 0; k < MAXS; k++) begin
      step("rwin", 1'b0, 1'b1, 1'b0, 1'b1);
      idle("rhold", HOLD + 1);
    end
    step("over_l", 1'b1, 1'b0, 1'b1, 1'b0);
    step("over_r", 1'b0, 1'b1, 1'b0, 1'b1);
    idle("over_idle", 4);
    hit_reset("reset_over");

    // 6: reset two cycles into a right show
    step("rwin6", 1'b0, 1'b1, 1'b0, 1'b1);
    idle("r6hold", 2);
    hit_reset("reset_show");
    idle("after_reset", HOLD + 3);
    step("lwin6", 1'b1, 1'b0, 1'b1, 1'b0);
    idle("l6hold", HOLD + 2);

    // Randomized play with occasional resets
    for (int i = 0; i < 600; i++) begin
      bit l, r, le, re;
      l  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 3) == 0);
      le = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 2) == 0);
      step("rand", l, r, le, re);
      if ($urandom_range(0, 79) == 0 || (gameOver && $urandom_range(0, 7) == 0))
        hit_reset("rand_reset");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
